ravan_mem_responder: RTL and testbench
======================================

Name: ravan_mem_responder

Overview:
- Memory-side responder for the RAVAN crypto engine's ciphertext store; sits at the far end of the engine's address/read-write memory interface.
- Accepts single-outstanding read/write requests over a valid/ready handshake and stores 64-bit ciphertext words with a per-word integrity tag.
- Returns read data, write acks and error status over a valid/ready response channel.
- Supports a bulk clear (scrub) of all stored words.

Parameters:
- ADDR_W, 32, request byte-address width
- DATA_W, 64, data word width (fixed 64; byte-lane math assumes 8 bytes)
- DEPTH, 256, number of stored words; power of two
- TAG_W, 8, integrity tag width
- READ_LAT, 2, cycles from read accept to resp_valid; legal range 1..8

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data (ciphertext)
- dbg_tag_flip  in  1  on an accepted write, store the tag with bit0 inverted (test hook)
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_wr  out  1  echo of req_wr for this response
- resp_rdata  out  DATA_W  read data; 0 for write responses
- resp_err  out  1  misaligned, out-of-range or tag mismatch
- clr_start  in  1  pulse: invalidate all words
- clr_done  out  1  one-cycle pulse when the clear completes
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): FSM to IDLE; all valid bits 0.
  - Outputs: req_ready=1 from the first clock after release; resp_valid=0, resp_rdata=0, resp_err=0, resp_wr=0, clr_done=0, busy=0.
  - Data/tag arrays are not reset.
  - Reset mid-transaction discards the in-flight request and any pending clear.
- Address decode:
  - index = req_addr >> 3.
  - Misaligned when req_addr[2:0] != 0.
  - Out of range when index >= DEPTH.
  - Either condition gives resp_err=1, no array access, resp_rdata=0.
- Tag = XOR of the 8 data bytes XOR index[7:0] (TAG_W=8). Computed on write; recomputed on read and compared with the stored tag.
- FSM states: IDLE, RD_WAIT, RESP, CLEAR.
  - IDLE: req_ready=1. Accept when req_valid & req_ready.
    - Accepted write (legal address): write data, tag and valid=1 in the accept cycle, then go to RESP. resp_valid rises the next cycle.
    - Accepted read: go to RD_WAIT with counter = READ_LAT-1. If READ_LAT=1, go directly to RESP.
    - Illegal address: go to RESP with err=1.
  - RD_WAIT: decrement the counter; at 0 go to RESP.
    - resp_valid rises exactly READ_LAT cycles after the accept edge.
  - RESP: resp_valid=1; resp_rdata, resp_err and resp_wr are held stable until resp_valid & resp_ready.
    - On handshake go to IDLE, or to CLEAR if a clear is pending.
    - req_ready=0 in every state except IDLE.
  - CLEAR: clears one valid bit per cycle, index 0..DEPTH-1; takes DEPTH cycles.
    - clr_done pulses in the cycle after the last index is cleared; then go to IDLE.
- Read of a legal word whose valid bit is 0: rdata=0, err=0, tag check skipped.
- Read with tag mismatch: rdata = stored data, err=1.
- clr_start handling:
  - In IDLE, clr_start has priority over a simultaneous req_valid; the request is not accepted.
  - In RD_WAIT or RESP, clr_start is latched as pending.
  - In CLEAR, clr_start is ignored.
- resp_ready asserted while resp_valid=0 is ignored.
- Writes use no byte enables.

Decomposition:
- Package ravan_mem_pkg: state enum (IDLE, RD_WAIT, RESP, CLEAR), WORD_BYTES=8 constant, tag-fold function, address-legality function.
- One sub-module: ravan_mem_array.
  - DEPTH x (DATA_W+TAG_W) storage with a registered read port.
  - Separate DEPTH-bit valid vector with a clear-by-index port.
  - Top level holds the FSM, latency counter, clear counter and response registers.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> all outputs 0, req_ready=1 on the first clk; read 0x0 -> rdata=0, err=0 after 2 cycles.
- Write 0x10 = 64'hDEADBEEF_CAFEF00D -> resp_valid one cycle after accept, resp_wr=1, err=0; read 0x10 -> resp_valid exactly 2 cycles after accept, rdata=64'hDEADBEEF_CAFEF00D, err=0.
- Write 0x13 (misaligned) and write 0x800 (index 256) -> each returns err=1; then read 0x0 and 0x10 -> contents unchanged.
- Backpressure: read 0x10 with resp_ready=0 for 5 cycles -> resp_valid=1, rdata stable, req_ready=0 throughout; handshake on cycle 6 -> req_ready=1 the next cycle.
- Write 0x18 = 64'h0123456789ABCDEF with dbg_tag_flip=1, then read 0x18 -> rdata=64'h0123456789ABCDEF, err=1.
- Assert clr_start while a read response is stalled -> clear starts after the handshake; req_ready=0 for 256 cycles; clr_done pulses once; read 0x10 -> rdata=0, err=0.

Source files
------------

// File: rtl/ravan_mem_pkg.sv
// Shared types and helpers for the RAVAN ciphertext-store responder.
// Holds the FSM state encoding, the word geometry, the tag fold and the address check.
package ravan_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  localparam int WORD_BYTES = 8;

  // Integrity tag: XOR of all data bytes, folded with the low byte of the word index.
  function automatic logic [7:0] tag_fold(input logic [63:0] data, input logic [7:0] idx);
    logic [7:0] acc;
    acc = idx;
    for (int b = 0; b < WORD_BYTES; b++) begin
      acc = acc ^ data[b*8 +: 8];
    end
    return acc;
  endfunction

  // A byte address is usable only when it is word aligned and its word index is in range.
  function automatic logic addr_legal(input logic [63:0] addr, input int unsigned depth);
    return (addr[2:0] == 3'd0) && ((addr >> 3) < 64'(depth));
  endfunction

endpackage

// File: rtl/ravan_mem_array.sv
// Word store for the responder: data+tag RAM with a registered read port,
// plus a per-word valid vector that can be cleared one index at a time.
module ravan_mem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TAG_W-1:0]         rd_tag,
  output logic                     rd_valid,
  input  logic                     clr_en,
  input  logic [$clog2(DEPTH)-1:0] clr_idx
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W+TAG_W-1:0] mem [DEPTH];
  logic [DATA_W+TAG_W-1:0] rd_word_reg;
  logic [DEPTH-1:0]        valid_vec;
  logic                    rd_valid_reg;

  // Payload storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= {wr_tag, wr_data};
    end
    if (rd_en) begin
      rd_word_reg <= mem[rd_idx];
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic v_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_reg <= 1'b0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          v_reg <= 1'b1;
        end else if (clr_en && (clr_idx == IDX_W'(gi))) begin
          v_reg <= 1'b0;
        end
      end
      assign valid_vec[gi] = v_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_reg <= 1'b0;
    end else if (rd_en) begin
      rd_valid_reg <= valid_vec[rd_idx];
    end
  end

  assign rd_data  = rd_word_reg[DATA_W-1:0];
  assign rd_tag   = rd_word_reg[DATA_W +: TAG_W];
  assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/ravan_mem_responder.sv
// Memory-side responder for the RAVAN ciphertext store: single-outstanding
// read/write requests, tagged word storage, held responses and a bulk scrub.
module ravan_mem_responder
  import ravan_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 256,
  parameter int TAG_W    = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              dbg_tag_flip,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_wr,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = 4;

  state_t           state_reg;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic [IDX_W-1:0] clr_cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             clr_pend_reg;
  logic             req_ready_reg;
  logic             resp_valid_reg;
  logic             resp_wr_reg;
  logic             addr_err_reg;
  logic             rd_mode_reg;
  logic             clr_done_reg;

  logic             legal;
  logic [IDX_W-1:0] req_idx;
  logic             accept;
  logic             arr_wr_en;
  logic             arr_rd_en;
  logic [TAG_W-1:0] wr_tag;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic             tag_bad;
  logic             resp_hit;

  assign legal   = addr_legal(64'(req_addr), DEPTH);
  assign req_idx = req_addr[IDX_W+2:3];
  // A clear request in IDLE wins over a request arriving in the same cycle.
  assign accept  = (state_reg == IDLE) && req_ready_reg && req_valid && !clr_start;

  assign arr_wr_en = accept && req_wr && legal;
  assign arr_rd_en = accept && !req_wr && legal;
  assign wr_tag    = TAG_W'(tag_fold(req_wdata, 8'(req_idx))) ^ TAG_W'(dbg_tag_flip);

  ravan_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (arr_wr_en),
    .wr_idx   (req_idx),
    .wr_data  (req_wdata),
    .wr_tag   (wr_tag),
    .rd_en    (arr_rd_en),
    .rd_idx   (req_idx),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .clr_en   (state_reg == CLEAR),
    .clr_idx  (clr_cnt_reg)
  );

  // The RAM output register is untouched until the next accept, so read data and
  // its tag check can be derived from it directly and still stay stable while held.
  assign tag_bad  = TAG_W'(tag_fold(rd_data, 8'(idx_reg))) != rd_tag;
  assign resp_hit = resp_valid_reg && rd_mode_reg && rd_valid;

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_wr    = resp_wr_reg;
  assign resp_rdata = resp_hit ? rd_data : '0;
  assign resp_err   = resp_valid_reg && (addr_err_reg || (resp_hit && tag_bad));
  assign clr_done   = clr_done_reg;
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      lat_cnt_reg    <= '0;
      clr_cnt_reg    <= '0;
      idx_reg        <= '0;
      clr_pend_reg   <= 1'b0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_wr_reg    <= 1'b0;
      addr_err_reg   <= 1'b0;
      rd_mode_reg    <= 1'b0;
      clr_done_reg   <= 1'b0;
    end else begin
      clr_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (clr_start) begin
            state_reg     <= CLEAR;
            clr_cnt_reg   <= '0;
            req_ready_reg <= 1'b0;
          end else if (accept) begin
            req_ready_reg <= 1'b0;
            resp_wr_reg   <= req_wr;
            addr_err_reg  <= !legal;
            rd_mode_reg   <= !req_wr && legal;
            idx_reg       <= req_idx;
            if (!req_wr && legal && (READ_LAT > 1)) begin
              state_reg   <= RD_WAIT;
              lat_cnt_reg <= LAT_W'(READ_LAT - 1);
            end else begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
            end
          end
        end

        RD_WAIT: begin
          if (clr_start) begin
            clr_pend_reg <= 1'b1;
          end
          if (lat_cnt_reg == LAT_W'(1)) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
          end
          lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
        end

        RESP: begin
          if (clr_start) begin
            clr_pend_reg <= 1'b1;
          end
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            resp_wr_reg    <= 1'b0;
            addr_err_reg   <= 1'b0;
            rd_mode_reg    <= 1'b0;
            if (clr_pend_reg || clr_start) begin
              state_reg    <= CLEAR;
              clr_cnt_reg  <= '0;
              clr_pend_reg <= 1'b0;
            end else begin
              state_reg     <= IDLE;
              req_ready_reg <= 1'b1;
            end
          end
        end

        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + IDX_W'(1);
          if (clr_cnt_reg == IDX_W'(DEPTH - 1)) begin
            state_reg     <= IDLE;
            clr_done_reg  <= 1'b1;
            req_ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ravan_mem_responder.sv
// Directed bench for ravan_mem_responder: hand-computed responses, latencies,
// backpressure, tag-fault hook, mid-transaction reset and the bulk clear.
module tb_ravan_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        dbg_tag_flip = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_wr;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        clr_start = 1'b0;
  logic        clr_done;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] D_A = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] D_B = 64'h01234567_89ABCDEF;

  ravan_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .dbg_tag_flip (dbg_tag_flip),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_wr      (resp_wr),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .clr_start    (clr_start),
    .clr_done     (clr_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request/response; hold = cycles of resp_ready=0 after resp_valid,
  // clr = pulse clr_start during the first stalled cycle.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic flip, input int exp_lat, input logic [63:0] exp_rdata,
                      input logic exp_err, input int hold, input logic clr);
    int lat;
    check("req_ready_idle", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; dbg_tag_flip = flip;
    step();
    req_valid = 1'b0; dbg_tag_flip = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      step();
      lat++;
    end
    check("resp_latency", 64'(lat), 64'(exp_lat));
    check("resp_wr", 64'(resp_wr), 64'(wr));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_err", 64'(resp_err), 64'(exp_err));
    check("req_ready_busy", 64'(req_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      if (clr && i == 0) clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      check("hold_valid", 64'(resp_valid), 64'(1));
      check("hold_rdata", resp_rdata, exp_rdata);
      check("hold_err", 64'(resp_err), 64'(exp_err));
      check("hold_req_ready", 64'(req_ready), 64'(0));
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_valid_drop", 64'(resp_valid), 64'(0));
    check("req_ready_after", 64'(req_ready), 64'(!clr));
    check("busy_after", 64'(busy), 64'(clr));
    $display("xact wr=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%0b", wr, addr, wdata, lat, exp_rdata, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;

    // Reset held for 3 cycles, then released between edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b1;
    step();
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_resp_rdata", resp_rdata, 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    check("rst_resp_wr", 64'(resp_wr), 64'(0));
    check("rst_clr_done", 64'(clr_done), 64'(0));

    // Unwritten word, then write/read of 0x10.
    xact(1'b0, 32'h0, '0, 1'b0, 2, 64'(0), 1'b0, 0, 1'b0);
    xact(1'b1, 32'h10, D_A, 1'b0, 1, 64'(0), 1'b0, 0, 1'b0);
    xact(1'b0, 32'h10, '0, 1'b0, 2, D_A, 1'b0, 0, 1'b0);

    // Illegal addresses: misaligned and out of range (index 256 would alias 0).
    xact(1'b1, 32'h13, 64'h5555_5555_5555_5555, 1'b0, 1, 64'(0), 1'b1, 0, 1'b0);
    xact(1'b1, 32'h800, 64'h1111_2222_3333_4444, 1'b0, 1, 64'(0), 1'b1, 0, 1'b0);
    xact(1'b0, 32'h13, '0, 1'b0, 1, 64'(0), 1'b1, 0, 1'b0);
    xact(1'b0, 32'h0, '0, 1'b0, 2, 64'(0), 1'b0, 0, 1'b0);
    xact(1'b0, 32'h10, '0, 1'b0, 2, D_A, 1'b0, 0, 1'b0);

    // Backpressure for 5 cycles.
    xact(1'b0, 32'h10, '0, 1'b0, 2, D_A, 1'b0, 5, 1'b0);

    // Corrupted tag via the debug hook.
    xact(1'b1, 32'h18, D_B, 1'b1, 1, 64'(0), 1'b0, 0, 1'b0);
    xact(1'b0, 32'h18, '0, 1'b0, 2, D_B, 1'b1, 0, 1'b0);

    // Reset while a read is in flight: request dropped, valid bits cleared.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    check("midrst_busy_pre", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_resp_valid", 64'(resp_valid), 64'(0));
    step();
    rst = 1'b1;
    step();
    check("midrst_req_ready", 64'(req_ready), 64'(1));
    xact(1'b0, 32'h10, '0, 1'b0, 2, 64'(0), 1'b0, 0, 1'b0);

    // Clear requested while a read response is stalled.
    xact(1'b1, 32'h10, D_A, 1'b0, 1, 64'(0), 1'b0, 0, 1'b0);
    xact(1'b0, 32'h10, '0, 1'b0, 2, D_A, 1'b0, 2, 1'b1);
    n = 0;
    pulses = 0;
    while (!req_ready && n < 400) begin
      if (clr_done) pulses++;
      n++;
      step();
    end
    check("clr_cycles", 64'(n), 64'(256));
    check("clr_done_pulse", 64'(clr_done), 64'(1));
    check("clr_done_early", 64'(pulses), 64'(0));
    check("clr_busy_end", 64'(busy), 64'(0));
    step();
    check("clr_done_single", 64'(clr_done), 64'(0));
    $display("clear took %0d cycles", n);
    xact(1'b0, 32'h10, '0, 1'b0, 2, 64'(0), 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
